// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I pipeline.
//   XLEN             - architectural register / address width
//   NOP_INSTR        - canonical NOP encoding (addi x0, x0, 0)
//   DEFAULT_RESET_PC - default PC loaded on reset
//   if_id_t          - IF/ID pipeline register contents
//   IF_ID_BUBBLE     - IF/ID contents when no real instruction is held
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/loop_detector.sv
// Terminal self-loop detector.
// Counts consecutive redirects whose target equals the branch's own PC and
// raises a sticky halt once LOOP_THRESH of them have been seen in a row.
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   redirect  - an accepted, aligned redirect happens this cycle
//   self_loop - the redirect target equals the resolving branch PC
//   halt      - sticky halt flag
module loop_detector #(
    parameter int unsigned LOOP_THRESH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic redirect,
    input  logic self_loop,
    output logic halt
);

    localparam int unsigned CW = $clog2(LOOP_THRESH + 1);
    localparam logic [CW:0] THRESH = (CW + 1)'(LOOP_THRESH);

    logic [CW-1:0] count;
    logic [CW:0]   count_inc;

    // One extra bit so the increment cannot wrap before the compare.
    assign count_inc = {1'b0, count} + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            halt  <= 1'b0;
        end else if (redirect) begin
            if (self_loop) begin
                if (count_inc >= THRESH) begin
                    halt  <= 1'b1;
                    count <= THRESH[CW-1:0];
                end else begin
                    count <= count_inc[CW-1:0];
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage.
// Owns the PC, drives the instruction-memory address, loads the IF/ID
// register, applies stalls and taken-branch flushes, traps misaligned branch
// targets and freezes fetch on a detected terminal self-loop.
//   clk, rst         - clock and synchronous active-high reset
//   i_mem_addr_o     - instruction address (the PC register)
//   i_mem_rdata_i    - instruction word for i_mem_addr_o, same cycle
//   stall_i          - hold PC and IF/ID
//   branch_taken_i   - redirect request from EX
//   branch_target_i  - redirect target
//   branch_pc_i      - PC of the resolving branch
//   if_id_pc_o       - PC of the instruction in IF/ID
//   if_id_instr_o    - instruction in IF/ID (NOP when invalid)
//   if_id_valid_o    - IF/ID holds a real instruction
//   halted_o         - sticky self-loop halt
//   misaligned_o     - sticky misaligned-target trap
//   fault_pc_o       - the misaligned target that caused the trap
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned     LOOP_THRESH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] i_mem_addr_o,
    input  logic [XLEN-1:0] i_mem_rdata_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] branch_pc_i,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic            if_id_valid_o,
    output logic            halted_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] fault_pc_o
);

    logic [XLEN-1:0] pc;
    if_id_t          if_id;
    logic            misaligned;
    logic [XLEN-1:0] fault_pc;
    logic            halted;
    logic            frozen;
    logic            target_misaligned;
    logic            aligned_redirect;

    assign frozen            = halted | misaligned;
    assign target_misaligned = (branch_target_i[1:0] != 2'b00);
    assign aligned_redirect  = ~frozen & branch_taken_i & ~target_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            if_id      <= IF_ID_BUBBLE;
            misaligned <= 1'b0;
            fault_pc   <= '0;
        end else if (frozen) begin
            if_id <= IF_ID_BUBBLE;
        end else if (branch_taken_i && target_misaligned) begin
            misaligned <= 1'b1;
            fault_pc   <= branch_target_i;
            if_id      <= IF_ID_BUBBLE;
        end else if (branch_taken_i) begin
            // Redirect wins over stall: the word in IF is wrong-path.
            pc    <= branch_target_i;
            if_id <= IF_ID_BUBBLE;
        end else if (!stall_i) begin
            pc    <= pc + 32'd4;
            if_id <= '{pc: pc, instr: i_mem_rdata_i, valid: 1'b1};
        end
    end

    loop_detector #(
        .LOOP_THRESH (LOOP_THRESH)
    ) u_loop_detector (
        .clk       (clk),
        .rst       (rst),
        .redirect  (aligned_redirect),
        .self_loop (branch_target_i == branch_pc_i),
        .halt      (halted)
    );

    assign i_mem_addr_o  = pc;
    assign if_id_pc_o    = if_id.pc;
    assign if_id_instr_o = if_id.instr;
    assign if_id_valid_o = if_id.valid;
    assign halted_o      = halted;
    assign misaligned_o  = misaligned;
    assign fault_pc_o    = fault_pc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, free-run, stall, redirect with
// stall, self-loop halt, count restart, mid-run reset, misaligned trap and
// PC wrap-around. Instruction memory returns ADDI x0,x0,addr[11:0].
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_mem_addr_o;
    logic [31:0] i_mem_rdata_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic [31:0] branch_pc_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic        halted_o;
    logic        misaligned_o;
    logic [31:0] fault_pc_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[11:0], 20'h00013};
    endfunction

    assign i_mem_rdata_i = mem_word(i_mem_addr_o);

    if_fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .LOOP_THRESH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_mem_addr_o    (i_mem_addr_o),
        .i_mem_rdata_i   (i_mem_rdata_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .branch_pc_i     (branch_pc_i),
        .if_id_pc_o      (if_id_pc_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_valid_o   (if_id_valid_o),
        .halted_o        (halted_o),
        .misaligned_o    (misaligned_o),
        .fault_pc_o      (fault_pc_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},   i_mem_addr_o,  32'h0);
        check({tag, "_pc"},     if_id_pc_o,    32'h0);
        check({tag, "_instr"},  if_id_instr_o, 32'h0000_0013);
        check({tag, "_valid"},  {31'b0, if_id_valid_o}, 32'h0);
        check({tag, "_halted"}, {31'b0, halted_o},      32'h0);
        check({tag, "_mis"},    {31'b0, misaligned_o},  32'h0);
        check({tag, "_fault"},  fault_pc_o,    32'h0);
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic [31:0] bpc, input logic exp_halt);
        branch_taken_i  = 1'b1;
        branch_target_i = tgt;
        branch_pc_i     = bpc;
        step();
        branch_taken_i = 1'b0;
        check("redir_addr",  i_mem_addr_o, tgt);
        check("redir_valid", {31'b0, if_id_valid_o}, 32'h0);
        check("redir_halt",  {31'b0, halted_o}, {31'b0, exp_halt});
    endtask

    initial begin
        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = '0;
        branch_pc_i     = '0;

        // Reset
        step();
        step();
        check_reset_values("rst");
        rst = 1'b0;
        check("run_addr0", i_mem_addr_o, 32'h0);

        // Free run: address steps by 4, IF/ID lags one cycle
        for (int k = 1; k <= 4; k++) begin
            step();
            check("run_addr",  i_mem_addr_o, 32'(4 * k));
            check("run_pc",    if_id_pc_o,   32'(4 * (k - 1)));
            check("run_instr", if_id_instr_o, mem_word(32'(4 * (k - 1))));
            check("run_valid", {31'b0, if_id_valid_o}, 32'h1);
        end

        // Stall three cycles at PC=0x10
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_addr",  i_mem_addr_o,  32'h10);
            check("stall_pc",    if_id_pc_o,    32'h0C);
            check("stall_instr", if_id_instr_o, mem_word(32'h0C));
            check("stall_valid", {31'b0, if_id_valid_o}, 32'h1);
        end
        stall_i = 1'b0;
        step();
        check("resume_addr", i_mem_addr_o, 32'h14);
        check("resume_pc",   if_id_pc_o,   32'h10);

        // Redirect to 0x40 together with stall
        stall_i = 1'b1;
        redirect(32'h40, 32'h08, 1'b0);
        stall_i = 1'b0;
        check("flush_instr", if_id_instr_o, 32'h0000_0013);
        check("flush_pc",    if_id_pc_o,    32'h0);
        step();
        check("tgt_pc",    if_id_pc_o,    32'h40);
        check("tgt_instr", if_id_instr_o, mem_word(32'h40));
        check("tgt_valid", {31'b0, if_id_valid_o}, 32'h1);
        check("tgt_addr",  i_mem_addr_o,  32'h44);

        // Reach 0x134 with a non-self redirect, then three self-loops
        redirect(32'h134, 32'h100, 1'b0);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            redirect(32'h134, 32'h134, 1'b0);
            step();
            step();
        end
        // A different target restarts the count: three more self-loops stay running
        redirect(32'h134, 32'h120, 1'b0);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            redirect(32'h134, 32'h134, 1'b0);
            check("noh_run", i_mem_addr_o, 32'h134);
            step();
            check("noh_adv", i_mem_addr_o, 32'h138);
            step();
        end
        // Fourth consecutive self-loop halts
        redirect(32'h134, 32'h134, 1'b1);
        step();
        check("halt_addr",  i_mem_addr_o, 32'h134);
        check("halt_valid", {31'b0, if_id_valid_o}, 32'h0);
        check("halt_instr", if_id_instr_o, 32'h0000_0013);
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h200;
        branch_pc_i     = 32'h10;
        step();
        branch_taken_i = 1'b0;
        check("halt_ignore_addr", i_mem_addr_o, 32'h134);
        check("halt_sticky",      {31'b0, halted_o}, 32'h1);

        // Reset mid-operation with stall and a (misaligned) redirect asserted
        rst             = 1'b1;
        stall_i         = 1'b1;
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h42;
        branch_pc_i     = 32'h0;
        step();
        check_reset_values("midrst");
        rst            = 1'b0;
        stall_i        = 1'b0;
        branch_taken_i = 1'b0;
        step();
        step();
        check("pre_mis_addr", i_mem_addr_o, 32'h08);

        // Misaligned target traps and freezes
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h42;
        branch_pc_i     = 32'h08;
        step();
        check("mis_flag",  {31'b0, misaligned_o}, 32'h1);
        check("mis_fault", fault_pc_o,   32'h42);
        check("mis_addr",  i_mem_addr_o, 32'h08);
        check("mis_valid", {31'b0, if_id_valid_o}, 32'h0);
        branch_target_i = 32'h80;
        step();
        check("mis_ign_addr", i_mem_addr_o, 32'h08);
        branch_target_i = 32'h46;
        step();
        branch_taken_i = 1'b0;
        check("mis_ign_fault", fault_pc_o,   32'h42);
        check("mis_ign_valid", {31'b0, if_id_valid_o}, 32'h0);
        check("mis_no_halt",   {31'b0, halted_o}, 32'h0);

        // PC wrap-around
        rst = 1'b1;
        step();
        rst = 1'b0;
        redirect(32'hFFFF_FFFC, 32'h0, 1'b0);
        step();
        check("wrap_addr",  i_mem_addr_o, 32'h0);
        check("wrap_pc",    if_id_pc_o,   32'hFFFF_FFFC);
        check("wrap_instr", if_id_instr_o, mem_word(32'hFFFF_FFFC));
        check("wrap_valid", {31'b0, if_id_valid_o}, 32'h1);
        check("wrap_mis",   {31'b0, misaligned_o},  32'h0);
        check("wrap_halt",  {31'b0, halted_o},      32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the RV32I five-stage pipeline, directly upstream of the ID stage and the consumer of the EX-stage branch unit's redirect. It owns the PC register, drives the combinational instruction-memory address, captures fetched words into the IF/ID pipeline register, and applies stalls and taken-branch flushes. It also flags misaligned branch targets and detects a terminal self-loop such as `j .`, freezing fetch so a bench or top level can end a run deterministically.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- LOOP_THRESH, 4, consecutive self-loop redirects before halt (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_mem_addr_o  out  32  instruction address; equals PC register
- i_mem_rdata_i  in  32  instruction word, valid in the same cycle as address
- stall_i  in  1  hazard-unit stall; hold PC and IF/ID
- branch_taken_i  in  1  EX branch unit redirect request
- branch_target_i  in  32  redirect target
- branch_pc_i  in  32  PC of the resolving branch
- if_id_pc_o  out  32  PC of instruction in IF/ID
- if_id_instr_o  out  32  instruction in IF/ID; NOP when invalid
- if_id_valid_o  out  1  IF/ID holds a real instruction
- halted_o  out  1  sticky; self-loop detected
- misaligned_o  out  1  sticky; branch target[1:0] ≠ 0
- fault_pc_o  out  32  misaligned target, captured once

## Operation
- Reset: PC=RESET_PC; if_id_pc=0, if_id_instr=32'h0000_0013, if_id_valid=0; halted=0, misaligned=0, fault_pc=0; loop count=0.
- Frozen state = halted_o | misaligned_o. While frozen: PC holds, IF/ID loads bubble (valid=0, instr=NOP, pc=0), all inputs ignored. Only rst clears it.
- Per-cycle priority when not frozen:
  - 1. branch_taken_i with target[1:0]≠0 → misaligned=1, fault_pc=target, PC holds, IF/ID bubble.
  - 2. branch_taken_i aligned → PC=target, IF/ID bubble. Flushes the wrong-path word in IF. Flushing ID/EX is the ID stage's job. Redirect overrides stall_i.
  - 3. stall_i → PC and IF/ID hold unchanged.
  - 4. otherwise → PC=PC+4 (mod 2^32, wraps 0xFFFF_FFFC→0), IF/ID={PC, i_mem_rdata_i, 1}.
- Self-loop detection, aligned redirects only:
  - branch_target_i == branch_pc_i → count+1.
  - Any other redirect → count=0.
  - Non-redirect cycles leave count unchanged.
  - When count+1 reaches LOOP_THRESH, halted=1 on that edge. The redirect still loads PC=target.
  - Count saturates at LOOP_THRESH.

## Timing
- Fetch latency: word at i_mem_addr_o in cycle n appears on if_id_* after edge n.
- Redirect asserted in cycle n: i_mem_addr_o=target in cycle n+1. if_id_valid_o=0 in cycle n+1. Target instruction is in IF/ID at cycle n+2.
- With EX resolution, a taken branch costs 2 bubbles. One comes from this block; one comes from the ID/EX flush.
- A `j .` loop redirects every 3 cycles. With LOOP_THRESH=4, halted_o rises within 12 cycles of the first self-redirect.
- halted_o and misaligned_o are registered and rise the edge after the triggering cycle.
- rst asserted mid-operation: every output takes its reset value after the next edge, regardless of stall or redirect.

## Structure
- Shared package cpu_pkg:
  - NOP_INSTR = 32'h0000_0013
  - XLEN = 32
  - default RESET_PC
- Sub-module loop_detector (parameter LOOP_THRESH):
  - inputs: clk, rst, redirect strobe, self-loop compare
  - output: sticky halt
  - contents: counter plus saturation logic
- PC/IF/ID datapath stays in if_fetch_stage.

## Test plan
- Reset then free-run over memory holding sequential ADDIs:
  - i_mem_addr_o steps 0,4,8,…
  - if_id_pc_o lags by one cycle with valid=1.
  - outputs are exact reset values during rst.
- stall_i high for 3 cycles at PC=0x10:
  - PC holds 0x10; IF/ID holds instruction from 0xC.
  - sequence resumes at 0x14 after release.
- branch_taken_i=1, target=0x40 with stall_i=1 in the same cycle:
  - next cycle addr=0x40, valid=0.
  - cycle after, if_id_pc_o=0x40.
- Branch target 0x42:
  - misaligned_o=1, fault_pc_o=0x42, PC frozen, valid stays 0.
  - later redirects ignored until rst.
- Program ending with `j .` at 0x134:
  - 4 self-redirects → halted_o=1, i_mem_addr_o=0x134 steady.
  - a loop with 3 iterations to a different target never halts.
- PC=0xFFFF_FFFC, no stall: next PC = 0x0000_0000, no flag raised.
